// File: rtl/count_wrap_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_wrap_monitor_pkg
// Description : Shared types and constants for the count wrap monitor: FSM
//               state encoding, down-counter width, wrap value and the
//               saturation ceiling of the wrap total.
// Revision    : 1.0 - initial release
// ============================================================================
package count_wrap_monitor_pkg;

    localparam int COUNT_W = 4;
    localparam int TOTAL_W = 8;

    localparam logic [COUNT_W-1:0] WRAP_TOP       = 4'd15;
    localparam logic [TOTAL_W-1:0] WRAP_TOTAL_MAX = 8'd255;

    // Explicit 2-bit encoding keeps the state register width fixed
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ALARM = 2'd2
    } state_t;

endpackage : count_wrap_monitor_pkg
`default_nettype wire

// File: rtl/count_wrap_monitor_wrap_detect.sv
`default_nettype none
// ============================================================================
// Module      : wrap_detect
// Description : Tracks the previous down-counter sample and flags a wrap
//               (previous value 0, current value 15) at the current edge.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous active-high reset
//               count_in - down-counter value sampled every edge
//               wrap     - combinational strobe, high when this edge sees a wrap
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_detect
    import count_wrap_monitor_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] count_in,
    output logic               wrap
);

    logic [COUNT_W-1:0] r_prev_count;
    logic               r_prev_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_count <= '0;
            r_prev_valid <= 1'b0;
        end else begin
            r_prev_count <= count_in;
            r_prev_valid <= 1'b1;
        end
    end

    // prev_valid blocks a false wrap on the first edge after reset, where
    // the forced prev_count of 0 is not a real sample.
    assign wrap = r_prev_valid && (r_prev_count == '0) && (count_in == WRAP_TOP);

endmodule : wrap_detect
`default_nettype wire

// File: rtl/count_wrap_monitor.sv
`default_nettype none
// ============================================================================
// Module      : count_wrap_monitor
// Description : Watches a 4-bit down counter for wraps (0 -> 15). Counts all
//               wraps (saturating), and once armed raises an alarm after
//               THRESH wraps. Wraps during an alarm set a sticky overrun.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous active-high reset
//               count_in   - down-counter value
//               arm        - start/restart wrap counting
//               ack        - alarm acknowledge
//               wrap_pulse - one-cycle pulse per detected wrap
//               wrap_total - saturating count of wraps since reset
//               alarm      - FSM is in ALARM
//               armed      - FSM is in ARMED
//               overrun    - sticky: wrap seen while in ALARM
// Revision    : 1.0 - initial release
// ============================================================================
module count_wrap_monitor
    import count_wrap_monitor_pkg::*;
#(
    parameter int THRESH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] count_in,
    input  logic               arm,
    input  logic               ack,
    output logic               wrap_pulse,
    output logic [TOTAL_W-1:0] wrap_total,
    output logic               alarm,
    output logic               armed,
    output logic               overrun
);

    localparam logic [COUNT_W-1:0] c_thresh_last = COUNT_W'(THRESH - 1);

    logic               w_wrap;
    state_t             r_state,     w_state_nxt;
    logic [COUNT_W-1:0] r_arm_wraps, w_arm_wraps_nxt;
    logic               r_overrun,   w_overrun_nxt;
    logic               r_wrap_pulse;
    logic [TOTAL_W-1:0] r_wrap_total;

    wrap_detect u_wrap_detect (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .wrap     (w_wrap)
    );

    // State register plus the counters that travel with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_arm_wraps  <= '0;
            r_overrun    <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_wrap_total <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_arm_wraps  <= w_arm_wraps_nxt;
            r_overrun    <= w_overrun_nxt;
            r_wrap_pulse <= w_wrap;
            if (w_wrap && (r_wrap_total != WRAP_TOTAL_MAX))
                r_wrap_total <= r_wrap_total + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt     = r_state;
        w_arm_wraps_nxt = r_arm_wraps;
        w_overrun_nxt   = r_overrun;
        case (r_state)
            IDLE: begin
                if (arm) begin
                    w_state_nxt     = ARMED;
                    w_arm_wraps_nxt = '0;
                end
            end
            ARMED: begin
                // A coincident arm restarts counting and discards the wrap
                if (arm) begin
                    w_arm_wraps_nxt = '0;
                end else if (w_wrap) begin
                    if (r_arm_wraps == c_thresh_last)
                        w_state_nxt = ALARM;
                    else
                        w_arm_wraps_nxt = r_arm_wraps + 1'b1;
                end
            end
            ALARM: begin
                // ack dominates both arm and a coincident wrap
                if (ack) begin
                    w_state_nxt   = IDLE;
                    w_overrun_nxt = 1'b0;
                end else if (w_wrap) begin
                    w_overrun_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_arm_wraps_nxt = '0;
                w_overrun_nxt   = 1'b0;
            end
        endcase
    end

    // Outputs decode registered state only
    always_comb begin
        alarm      = (r_state == ALARM);
        armed      = (r_state == ARMED);
        overrun    = r_overrun;
        wrap_pulse = r_wrap_pulse;
        wrap_total = r_wrap_total;
    end

endmodule : count_wrap_monitor
`default_nettype wire

// File: tb/tb_count_wrap_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_wrap_monitor
// Description : Self-checking bench for count_wrap_monitor (THRESH=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_wrap_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] count_in;
    logic       arm;
    logic       ack;
    logic       wrap_pulse;
    logic [7:0] wrap_total;
    logic       alarm;
    logic       armed;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [3:0] cnt;
        logic       arm;
        logic       ack;
        logic       pulse;
        logic [7:0] total;
        logic       alarm;
        logic       armed;
        logic       overrun;
    } vec_t;

    vec_t vecs[$];

    count_wrap_monitor #(.THRESH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .count_in   (count_in),
        .arm        (arm),
        .ack        (ack),
        .wrap_pulse (wrap_pulse),
        .wrap_total (wrap_total),
        .alarm      (alarm),
        .armed      (armed),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input int c, input logic a, input logic k,
                       input logic p, input int t, input logic al, input logic ar,
                       input logic ov);
        vec_t v;
        v.rst = r; v.cnt = 4'(c); v.arm = a; v.ack = k;
        v.pulse = p; v.total = 8'(t); v.alarm = al; v.armed = ar; v.overrun = ov;
        vecs.push_back(v);
    endtask

    // Non-wrapping descending run with constant expected outputs
    task automatic add_run(input int from, input int to, input int t,
                           input logic al, input logic ar, input logic ov);
        for (int c = from; c >= to; c--)
            add(1'b0, c, 1'b0, 1'b0, 1'b0, t, al, ar, ov);
    endtask

    task automatic apply(input logic r, input logic [3:0] c, input logic a, input logic k);
        rst = r; count_in = c; arm = a; ack = k;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got={pulse,total,alarm,armed,overrun}=%h required=%h", name, got, exp);
        end
    endtask

    initial begin
        int exp_total;
        rst = 1'b1; count_in = 4'd0; arm = 1'b0; ack = 1'b0;

        // reset state, then 2,1,0,15,14 with no arm (ack in IDLE ignored)
        add(1, 0, 0, 0,  0, 0, 0, 0, 0);
        add(0, 2, 0, 0,  0, 0, 0, 0, 0);
        add(0, 1, 0, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0, 0);
        add(0, 15, 0, 0, 1, 1, 0, 0, 0);
        add(0, 14, 0, 0, 0, 1, 0, 0, 0);
        add(0, 15, 0, 0, 0, 1, 0, 0, 0);   // 14->15 is not a wrap
        // arm, three wraps -> alarm with third pulse
        add(0, 14, 1, 0, 0, 1, 0, 1, 0);
        add_run(13, 0, 1, 0, 1, 0);
        add(0, 15, 0, 0, 1, 2, 0, 1, 0);
        add_run(14, 0, 2, 0, 1, 0);
        add(0, 15, 0, 0, 1, 3, 0, 1, 0);
        add_run(14, 0, 3, 0, 1, 0);
        add(0, 15, 0, 0, 1, 4, 1, 0, 0);
        // arm ignored in ALARM; extra wrap -> overrun; ack clears
        add(0, 14, 1, 0, 0, 4, 1, 0, 0);
        add_run(13, 0, 4, 1, 0, 0);
        add(0, 15, 0, 0, 1, 5, 1, 0, 1);
        add(0, 14, 0, 1, 0, 5, 0, 0, 0);
        // arm coincident with third wrap restarts counting
        add(0, 13, 1, 0, 0, 5, 0, 1, 0);
        add_run(12, 0, 5, 0, 1, 0);
        add(0, 15, 0, 0, 1, 6, 0, 1, 0);
        add_run(14, 0, 6, 0, 1, 0);
        add(0, 15, 0, 0, 1, 7, 0, 1, 0);
        add_run(14, 0, 7, 0, 1, 0);
        add(0, 15, 1, 0, 1, 8, 0, 1, 0);
        add_run(14, 0, 8, 0, 1, 0);
        add(0, 15, 0, 0, 1, 9, 0, 1, 0);
        add_run(14, 0, 9, 0, 1, 0);
        add(0, 15, 0, 0, 1, 10, 0, 1, 0);
        add_run(14, 0, 10, 0, 1, 0);
        add(0, 15, 0, 0, 1, 11, 1, 0, 0);
        // overrun, then reset mid-ALARM with arm/ack asserted
        add_run(14, 0, 11, 1, 0, 0);
        add(0, 15, 0, 0, 1, 12, 1, 0, 1);
        add_run(14, 1, 12, 1, 0, 1);
        add(1, 0, 1, 1,  0, 0, 0, 0, 0);
        add(0, 15, 0, 0, 0, 0, 0, 0, 0);   // first post-reset edge: no wrap
        // back to ALARM, then wrap and ack together
        add(0, 14, 1, 0, 0, 0, 0, 1, 0);
        add_run(13, 0, 0, 0, 1, 0);
        add(0, 15, 0, 0, 1, 1, 0, 1, 0);
        add_run(14, 0, 1, 0, 1, 0);
        add(0, 15, 0, 0, 1, 2, 0, 1, 0);
        add_run(14, 0, 2, 0, 1, 0);
        add(0, 15, 0, 0, 1, 3, 1, 0, 0);
        add_run(14, 0, 3, 1, 0, 0);
        add(0, 15, 0, 1, 1, 4, 0, 0, 0);
        add(0, 14, 0, 0, 0, 4, 0, 0, 0);
        // arm+ack together in ALARM -> IDLE
        add(0, 13, 1, 0, 0, 4, 0, 1, 0);
        add_run(12, 0, 4, 0, 1, 0);
        add(0, 15, 0, 0, 1, 5, 0, 1, 0);
        add_run(14, 0, 5, 0, 1, 0);
        add(0, 15, 0, 0, 1, 6, 0, 1, 0);
        add_run(14, 0, 6, 0, 1, 0);
        add(0, 15, 0, 0, 1, 7, 1, 0, 0);
        add(0, 14, 1, 1, 0, 7, 0, 0, 0);
        add(0, 13, 0, 1, 0, 7, 0, 0, 0);   // ack in IDLE ignored

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].cnt, vecs[i].arm, vecs[i].ack);
            check($sformatf("vec%0d", i),
                  {wrap_pulse, wrap_total, alarm, armed, overrun},
                  {vecs[i].pulse, vecs[i].total, vecs[i].alarm, vecs[i].armed, vecs[i].overrun});
        end

        // 260 wraps: total saturates at 255
        apply(1'b1, 4'd0, 1'b0, 1'b0);
        apply(1'b0, 4'd0, 1'b0, 1'b0);
        exp_total = 0;
        for (int n = 0; n < 260; n++) begin
            apply(1'b0, 4'd15, 1'b0, 1'b0);
            if (exp_total < 255) exp_total++;
            check($sformatf("sat_wrap%0d", n),
                  {wrap_pulse, wrap_total, alarm, armed, overrun},
                  {1'b1, 8'(exp_total), 3'b000});
            apply(1'b0, 4'd0, 1'b0, 1'b0);
        end
        check("sat_hold", {wrap_pulse, wrap_total, alarm, armed, overrun},
              {1'b0, 8'd255, 3'b000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_count_wrap_monitor
`default_nettype wire

// File: doc/count_wrap_monitor.md
COUNT_WRAP_MONITOR -- requirements
Module: count_wrap_monitor

Interface
REQ-001 Parameter THRESH, default 3, wrap events after arming before alarm; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 count_in  input  4  down-counter value, sampled every clock edge.
REQ-005 arm  input  1  single-cycle request to start or restart wrap counting.
REQ-006 ack  input  1  alarm acknowledge.
REQ-007 wrap_pulse  output  1  one-cycle pulse per detected wrap.
REQ-008 wrap_total  output  8  saturating count of all detected wraps since reset.
REQ-009 alarm  output  1  high while FSM is in ALARM.
REQ-010 armed  output  1  high while FSM is in ARMED.
REQ-011 overrun  output  1  sticky flag: a wrap occurred while in ALARM.

Function
REQ-012 The block SHALL register count_in every edge into prev_count and set prev_valid to 1 on the first edge after reset.
REQ-013 A wrap SHALL be detected at an edge when prev_valid=1, prev_count=0 and count_in=15; no other transition (including 14->15) is a wrap.
REQ-014 wrap_pulse SHALL be high for exactly the one cycle following the detecting edge; back-to-back wraps are impossible in a 4-bit down count and need no handling.
REQ-015 wrap_total SHALL increment on every detected wrap in any state and saturate at 255.
REQ-016 FSM states: IDLE, ARMED, ALARM; all outputs registered, no combinational input-to-output path.
REQ-017 IDLE: arm -> ARMED with arm_wraps cleared to 0; wraps only update wrap_total.
REQ-018 ARMED: wrap with arm_wraps=THRESH-1 -> ALARM; other wraps increment arm_wraps (4-bit).
REQ-019 ARMED: arm SHALL clear arm_wraps to 0 and stay ARMED; arm and wrap in same cycle -> arm wins, arm_wraps=0, wrap still counted in wrap_total.
REQ-020 ALARM: ack -> IDLE and clears overrun; arm alone ignored; arm and ack together -> IDLE (ack wins).
REQ-021 ALARM: a wrap without ack SHALL set overrun; wrap and ack in same cycle -> IDLE, overrun cleared, wrap counted in wrap_total only.
REQ-022 ack outside ALARM SHALL be ignored.
REQ-023 alarm SHALL rise in the same cycle wrap_pulse is high for the THRESH-th wrap (latency 1 edge from the sampled 15).

Reset
REQ-024 rst=1 at an edge SHALL force: state IDLE, prev_valid=0, prev_count=0, arm_wraps=0, wrap_total=0, wrap_pulse=0, alarm=0, armed=0, overrun=0.
REQ-025 rst SHALL take priority over arm, ack and wrap detection in the same cycle, including mid-ALARM.
REQ-026 The first edge after rst deasserts SHALL only load prev_count; no wrap can be detected on it.

Structure
REQ-027 A shared package SHALL hold the FSM state enumeration (IDLE/ARMED/ALARM), count width 4, WRAP_TOP=15 and WRAP_TOTAL_MAX=255.
REQ-028 Wrap detection (prev_count, prev_valid, wrap strobe) SHALL be a sub-module named wrap_detect; FSM and counters stay in the top.

Verification
REQ-029 Drive count_in 2,1,0,15,14 with no arm -> one wrap_pulse the cycle after 15 sampled; wrap_total=1; state stays IDLE.
REQ-030 arm, then three full 15..0 cycles (THRESH=3) -> alarm rises with third wrap_pulse; armed falls same cycle; ack -> alarm=0, IDLE next cycle.
REQ-031 In ALARM, hold ack=0 through one more wrap -> overrun=1, wrap_total increments; ack -> overrun=0.
REQ-032 ARMED with arm_wraps=2, pulse arm coincident with a wrap -> arm_wraps=0, no alarm, wrap_total increments.
REQ-033 Assert rst in ALARM with overrun=1 -> all outputs 0 next cycle; count_in=15 on first post-reset edge after prev 0 input -> no wrap_pulse.
REQ-034 Force 260 wraps -> wrap_total holds 255, no rollover.
